// File: rtl/pulse_pkg.sv
// Shared types and defaults for the TTL pulse generator / analyzer pair.
package pulse_pkg;

  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned COUNT_W_DEF = 16;
  localparam int unsigned TIMEOUT_DEF = 65536;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Pulse-train parameters; loopback compares analyzer results against this directly.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]   width;
    logic [CNT_W_DEF-1:0]   period;
    logic [COUNT_W_DEF-1:0] count;
  } pulse_params_t;

endpackage

// File: rtl/ttl_input_sync.sv
// Metastability synchronizer for an asynchronous input plus rise/fall detect.
module ttl_input_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the input through the synchronizer chain and keep one delayed copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ttl_pulse_analyzer.sv
// Measures one burst of TTL pulses: first width, first period, count, deviation and stuck-high flags.
module ttl_pulse_analyzer
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned TOL     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ttl_in,
  output logic [CNT_W-1:0]   meas_width,
  output logic [CNT_W-1:0]   meas_period,
  output logic [COUNT_W-1:0] meas_count,
  output logic               mismatch,
  output logic               stuck_high,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  localparam int unsigned        DIFF_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0]   HIGH_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   IDLE_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [DIFF_W-1:0]  TOL_X    = DIFF_W'(TOL);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [COUNT_W-1:0] PULSE_ONE = COUNT_W'(1);

  state_t            state_q, state_d;
  logic              rise_c, fall_c;
  logic [CNT_W-1:0]  width_cnt, period_cnt, idle_cnt;
  logic              first_c;

  // True when two measurements differ by more than the tolerance (no wrap).
  function automatic logic off_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [DIFF_W-1:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return d > TOL_X;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  ttl_input_sync #(.STAGES(2)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ttl_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign first_c = (meas_count == PULSE_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a rise beats the idle timeout, a fall beats the stuck timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise_c) state_d = HIGH;
      HIGH: begin
        if (fall_c)                      state_d = LOW;
        else if (width_cnt >= HIGH_MAX)  state_d = DONE;
      end
      LOW: begin
        if (rise_c)                      state_d = HIGH;
        else if (idle_cnt >= IDLE_MAX)   state_d = DONE;
      end
      DONE: if (result_valid && result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, latched measurements and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_cnt    <= '0;
      period_cnt   <= '0;
      idle_cnt     <= '0;
      meas_width   <= '0;
      meas_period  <= '0;
      meas_count   <= '0;
      mismatch     <= 1'b0;
      stuck_high   <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= (state_d == DONE);
      busy         <= (state_d == HIGH) || (state_d == LOW);
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            width_cnt   <= CNT_ONE;
            period_cnt  <= CNT_ONE;
            meas_count  <= PULSE_ONE;
            meas_width  <= '0;
            meas_period <= '0;
            mismatch    <= 1'b0;
            stuck_high  <= 1'b0;
          end
        end
        HIGH: begin
          width_cnt  <= sat_inc(width_cnt);
          period_cnt <= sat_inc(period_cnt);
          if (fall_c) begin
            idle_cnt <= '0;
            if (first_c)                             meas_width <= width_cnt;
            else if (off_tol(width_cnt, meas_width)) mismatch   <= 1'b1;
          end else if (width_cnt >= HIGH_MAX) begin
            stuck_high <= 1'b1;
            if (first_c) meas_width <= HIGH_MAX;
          end
        end
        LOW: begin
          period_cnt <= sat_inc(period_cnt);
          idle_cnt   <= sat_inc(idle_cnt);
          if (rise_c) begin
            if (first_c)                               meas_period <= period_cnt;
            else if (off_tol(period_cnt, meas_period)) mismatch    <= 1'b1;
            if (meas_count != '1) meas_count <= meas_count + PULSE_ONE;
            width_cnt  <= CNT_ONE;
            period_cnt <= CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttl_pulse_analyzer.sv
// Scoreboard bench for ttl_pulse_analyzer: directed pulse trains, monitor checks each result.
module tb_ttl_pulse_analyzer;
  import pulse_pkg::*;

  localparam int unsigned TO  = 4096;
  localparam int          LAT = 4096 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ttl_in = 1'b0;
  logic        result_ready = 1'b1;
  logic [31:0] meas_width, meas_period;
  logic [15:0] meas_count;
  logic        mismatch, stuck_high, result_valid, busy;

  typedef struct {
    pulse_params_t p;
    logic          mm;
    logic          sh;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;

  ttl_pulse_analyzer #(.CNT_W(32), .COUNT_W(16), .TIMEOUT(TO), .TOL(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ttl_in       (ttl_in),
    .meas_width   (meas_width),
    .meas_period  (meas_period),
    .meas_count   (meas_count),
    .mismatch     (mismatch),
    .stuck_high   (stuck_high),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_result(input int w, input int p, input int c, input logic mm,
                               input logic sh, input int lat);
    exp_t e;
    e.p.width  = 32'(w);
    e.p.period = 32'(p);
    e.p.count  = 16'(c);
    e.mm  = mm;
    e.sh  = sh;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Drive n pulses of width w every p cycles; pulse odd_idx gets width odd_w and extra gap odd_gap.
  task automatic pulse_train(input int w, input int p, input int n, input int odd_idx = -1,
                             input int odd_w = 0, input int odd_gap = 0);
    for (int i = 0; i < n; i++) begin
      int hw;
      hw = (i == odd_idx) ? odd_w : w;
      ttl_in = 1'b1;
      repeat (hw) @(negedge clk);
      ttl_in = 1'b0;
      last_fall_cyc = cyc;
      if (i < n - 1) repeat (p - hw + ((i == odd_idx) ? odd_gap : 0)) @(negedge clk);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!result_valid && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    check("result_arrives", result_valid, 1);
  endtask

  task automatic wait_result();
    wait_valid();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_width"},  meas_width, 0);
    check({tag, "_period"}, meas_period, 0);
    check({tag, "_count"},  meas_count, 0);
    check({tag, "_flags"},  {mismatch, stuck_high}, 0);
    check({tag, "_valid"},  result_valid, 0);
    check({tag, "_busy"},   busy, 0);
  endtask

  // Monitor: pop and compare on each new result; track stability until it is accepted.
  initial begin
    logic        was_valid;
    logic        unstable;
    logic [81:0] snap;
    exp_t        e;
    was_valid = 1'b0;
    unstable  = 1'b0;
    snap      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        was_valid = 1'b0;
      end else begin
        if (result_valid && !was_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("width",      meas_width, e.p.width);
            check("period",     meas_period, e.p.period);
            check("count",      meas_count, e.p.count);
            check("mismatch",   mismatch, e.mm);
            check("stuck_high", stuck_high, e.sh);
            check("busy_done",  busy, 0);
            if (e.lat >= 0) check("latency", cyc - last_fall_cyc, e.lat);
          end
          snap     = {meas_width, meas_period, meas_count, mismatch, stuck_high};
          unstable = 1'b0;
        end else if (result_valid) begin
          if ({meas_width, meas_period, meas_count, mismatch, stuck_high} !== snap || busy)
            unstable = 1'b1;
        end else if (was_valid) begin
          check("held_stable", unstable, 0);
        end
        was_valid = result_valid;
      end
    end
  end

  // Stimulus.
  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Regular train.
    expect_result(100, 1000, 10, 0, 0, LAT);
    pulse_train(100, 1000, 10);
    wait_result();

    // Single pulse, then a second burst.
    expect_result(50, 0, 1, 0, 0, LAT);
    pulse_train(50, 0, 1);
    wait_result();
    expect_result(300, 500, 15, 0, 0, LAT);
    pulse_train(300, 500, 15);
    wait_result();

    // Width deviation of 3 exceeds TOL=2; deviation of 2 does not.
    expect_result(200, 400, 6, 1, 0, LAT);
    pulse_train(200, 400, 6, 4, 203, 0);
    wait_result();
    expect_result(200, 400, 6, 0, 0, LAT);
    pulse_train(200, 400, 6, 4, 202, 0);
    wait_result();

    // Period deviation of 3 on the second period.
    expect_result(100, 250, 4, 1, 0, LAT);
    pulse_train(100, 250, 4, 1, 100, 3);
    wait_result();

    // Stuck high; a level that stays high in IDLE must not start a burst.
    expect_result(TO, 0, 1, 0, 1, -1);
    ttl_in = 1'b1;
    wait_result();
    repeat (50) @(negedge clk);
    check("high_level_no_burst", busy, 0);
    check("high_level_no_valid", result_valid, 0);
    ttl_in = 1'b0;
    repeat (10) @(negedge clk);

    // Result held while ready is low; edges in DONE are ignored.
    result_ready = 1'b0;
    expect_result(40, 120, 3, 0, 0, LAT);
    pulse_train(40, 120, 3);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      ttl_in = 1'b1;
      repeat (25) @(negedge clk);
      ttl_in = 1'b0;
      repeat (25) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("held_valid", result_valid, 1);
    result_ready = 1'b1;
    @(negedge clk);
    check("accept_drop_valid", result_valid, 0);
    check("accept_idle", busy, 0);
    expect_result(60, 150, 2, 0, 0, LAT);
    pulse_train(60, 150, 2);
    wait_result();

    // Reset in the middle of the third pulse discards the burst.
    pulse_train(100, 300, 2);
    repeat (200) @(negedge clk);
    ttl_in = 1'b1;
    repeat (50) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    ttl_in = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (TO + 100) @(negedge clk);
    check("no_partial_result", result_valid, 0);
    expect_result(100, 300, 10, 0, 0, LAT);
    pulse_train(100, 300, 10);
    wait_result();

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
